// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for write-back, decode and forwarding.
// Widths, link-register defaults and the hard-wired zero register.
package wb_regfile_pkg;
  localparam int WB_DATA_W   = 32;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_LINK_REG = 31;
  localparam int WB_LINK_OFS = 4;
  localparam int REG_ZERO    = 0;
endpackage

// File: rtl/wb_data_sel.sv
// Write-back source mux plus destination and enable generation.
// Link value wins over load data, which wins over the ALU result.
module wb_data_sel
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int LINK_REG = WB_LINK_REG,
  parameter int LINK_OFS = WB_LINK_OFS
) (
  input  logic [DATA_W-1:0] ALU_ans_Wr,
  input  logic [DATA_W-1:0] Mem_Data_Wr,
  input  logic [DATA_W-1:0] PC_Addr_Wr,
  input  logic [ADDR_W-1:0] Reg_Target_Wr,
  input  logic              MemToReg_Wr,
  input  logic              RegWr_Wr,
  input  logic              Rtype_L_Wr,
  input  logic              Jal_Wr,
  output logic              Wb_En,
  output logic [ADDR_W-1:0] Wb_Addr,
  output logic [DATA_W-1:0] Wb_Data
);

  logic [DATA_W-1:0] w_link;

  assign w_link = PC_Addr_Wr + DATA_W'(LINK_OFS);

  always_comb begin
    Wb_Data = ALU_ans_Wr;
    if (Jal_Wr || Rtype_L_Wr)
      Wb_Data = w_link;
    else if (MemToReg_Wr)
      Wb_Data = Mem_Data_Wr;
  end

  always_comb begin
    Wb_Addr = Reg_Target_Wr;
    if (Jal_Wr)
      Wb_Addr = ADDR_W'(LINK_REG);
  end

  // Jal commits regardless of RegWr; writes to r0 are never real
  assign Wb_En = (RegWr_Wr | Jal_Wr)
               & (Wb_Addr != ADDR_W'(REG_ZERO));

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: architectural register file with two bypassed
// read ports and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int LINK_REG = WB_LINK_REG,
  parameter int LINK_OFS = WB_LINK_OFS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ALU_ans_Wr,
  input  logic [DATA_W-1:0] Mem_Data_Wr,
  input  logic [DATA_W-1:0] PC_Addr_Wr,
  input  logic [ADDR_W-1:0] Reg_Target_Wr,
  input  logic              MemToReg_Wr,
  input  logic              RegWr_Wr,
  input  logic              Rtype_L_Wr,
  input  logic              Jal_Wr,
  input  logic [ADDR_W-1:0] Rs_Addr,
  input  logic [ADDR_W-1:0] Rt_Addr,
  output logic [DATA_W-1:0] Rs_Data,
  output logic [DATA_W-1:0] Rt_Data,
  output logic              Wb_En,
  output logic [ADDR_W-1:0] Wb_Addr,
  output logic [DATA_W-1:0] Wb_Data,
  output logic [31:0]       Wr_Count
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [31:0]       r_wr_count;

  wb_data_sel #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LINK_REG(LINK_REG),
    .LINK_OFS(LINK_OFS)
  ) u_sel (
    .ALU_ans_Wr   (ALU_ans_Wr),
    .Mem_Data_Wr  (Mem_Data_Wr),
    .PC_Addr_Wr   (PC_Addr_Wr),
    .Reg_Target_Wr(Reg_Target_Wr),
    .MemToReg_Wr  (MemToReg_Wr),
    .RegWr_Wr     (RegWr_Wr),
    .Rtype_L_Wr   (Rtype_L_Wr),
    .Jal_Wr       (Jal_Wr),
    .Wb_En        (Wb_En),
    .Wb_Addr      (Wb_Addr),
    .Wb_Data      (Wb_Data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_wr_count <= '0;
    end else if (Wb_En) begin
      r_regs[Wb_Addr] <= Wb_Data;
      r_wr_count      <= r_wr_count + 32'd1;
    end
  end

  // Write-through bypass is live even while rst is held
  always_comb begin
    Rs_Data = r_regs[Rs_Addr];
    if (Rs_Addr == ADDR_W'(REG_ZERO))
      Rs_Data = '0;
    else if (Wb_En && Rs_Addr == Wb_Addr)
      Rs_Data = Wb_Data;
  end

  always_comb begin
    Rt_Data = r_regs[Rt_Addr];
    if (Rt_Addr == ADDR_W'(REG_ZERO))
      Rt_Data = '0;
    else if (Wb_En && Rt_Addr == Wb_Addr)
      Rt_Data = Wb_Data;
  end

  assign Wr_Count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: behavioural register-file model, per-cycle
// compare, directed scenarios and randomized traffic with async resets.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, mem, pc;
  logic [4:0]  tgt, rs, rt;
  logic        m2r, regwr, rtl_l, jal;
  logic [31:0] rs_d, rt_d, wb_d, cnt;
  logic        wb_en;
  logic [4:0]  wb_a;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .ALU_ans_Wr   (alu),
    .Mem_Data_Wr  (mem),
    .PC_Addr_Wr   (pc),
    .Reg_Target_Wr(tgt),
    .MemToReg_Wr  (m2r),
    .RegWr_Wr     (regwr),
    .Rtype_L_Wr   (rtl_l),
    .Jal_Wr       (jal),
    .Rs_Addr      (rs),
    .Rt_Addr      (rt),
    .Rs_Data      (rs_d),
    .Rt_Data      (rt_d),
    .Wb_En        (wb_en),
    .Wb_Addr      (wb_a),
    .Wb_Data      (wb_d),
    .Wr_Count     (cnt)
  );

  function automatic logic [4:0] m_dest();
    return jal ? 5'd31 : tgt;
  endfunction

  function automatic logic [31:0] m_data();
    if (jal || rtl_l) return pc + 32'd4;
    if (m2r) return mem;
    return alu;
  endfunction

  function automatic logic m_en();
    return (regwr || jal) && (m_dest() != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_en() && a == m_dest()) return m_data();
    return m_regs[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (m_en()) begin
      m_regs[m_dest()] = m_data();
      m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the clock edge
  always @(negedge clk) begin
    chk("rs_data", rs_d, m_read(rs));
    chk("rt_data", rt_d, m_read(rt));
    chk("wb_en", {31'd0, wb_en}, {31'd0, m_en()});
    chk("wb_addr", {27'd0, wb_a}, {27'd0, m_dest()});
    chk("wb_data", wb_d, m_data());
    chk("wr_count", cnt, m_cnt);
  end

  task automatic idle();
    alu = '0; mem = '0; pc = '0; tgt = '0;
    m2r = 0; regwr = 0; rtl_l = 0; jal = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs = 0; rt = 0;
    #12;
    chk("reset_cnt", cnt, 32'd0);
    rst = 1'b0;
    step();

    // ALU write to r8 with same-cycle bypass
    regwr = 1; tgt = 8; alu = 32'h12345678; rs = 8; rt = 8;
    #1;
    chk("alu_bypass", rs_d, 32'h12345678);
    chk("alu_bypass_rt", rt_d, 32'h12345678);
    step();
    idle();
    #1;
    chk("alu_stored", rs_d, 32'h12345678);
    chk("alu_count", cnt, 32'd1);

    // Load beats ALU
    regwr = 1; m2r = 1; tgt = 9; mem = 32'hDEADBEEF; alu = 32'h1;
    step();
    idle(); rt = 9;
    #1;
    chk("load_stored", rt_d, 32'hDEADBEEF);

    regwr = 1; tgt = 4; alu = 32'h55;
    step();

    // Jal ignores RegWr and Reg_Target
    idle(); jal = 1; pc = 32'h00400010; tgt = 5; rs = 31; rt = 5;
    #1;
    chk("jal_bypass", rs_d, 32'h00400014);
    chk("jal_addr", {27'd0, wb_a}, 32'd31);
    step();
    idle();
    #1;
    chk("jal_r31", rs_d, 32'h00400014);
    chk("jal_r5", rt_d, 32'd0);

    // Rtype link with PC wrap
    rtl_l = 1; regwr = 1; tgt = 4; pc = 32'hFFFFFFFC; rs = 4;
    step();
    idle();
    #1;
    chk("rtl_wrap", rs_d, 32'd0);
    chk("rtl_count", cnt, 32'd5);

    // Writes to r0 vanish
    regwr = 1; tgt = 0; alu = 32'hFFFFFFFF; rs = 0;
    #1;
    chk("r0_read", rs_d, 32'd0);
    chk("r0_en", {31'd0, wb_en}, 32'd0);
    step();
    idle();
    #1;
    chk("r0_count", cnt, 32'd5);

    // Both jal and rtype link: jal destination wins
    jal = 1; rtl_l = 1; regwr = 1; tgt = 7; pc = 32'h100;
    rs = 31; rt = 7;
    step();
    idle();

    // Randomized traffic with occasional mid-cycle async reset
    for (int n = 0; n < 3000; n++) begin
      alu   = $urandom; mem = $urandom; pc = $urandom;
      tgt   = 5'($urandom);
      m2r   = 1'($urandom);
      regwr = ($urandom_range(0, 3) != 0);
      rtl_l = ($urandom_range(0, 7) == 0);
      jal   = ($urandom_range(0, 7) == 0);
      rs    = ($urandom_range(0, 3) == 0) ? tgt : 5'($urandom);
      rt    = ($urandom_range(0, 3) == 0) ? rs  : 5'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end

    // Async reset between edges clears storage and counter
    idle(); regwr = 1;
    for (int i = 1; i < 6; i++) begin
      tgt = 5'(i); alu = 32'hA0 + 32'(i);
      step();
    end
    idle(); rs = 3; rt = 5;
    #1;
    chk("pre_rst_r3", rs_d, 32'hA3);
    #1 rst = 1'b1;
    #1;
    chk("rst_rs", rs_d, 32'd0);
    chk("rst_rt", rt_d, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the five-stage pipeline. Consumes the MEM/WR pipeline register outputs, selects the write-back value and destination, and commits it to a 32×32-bit register file on the clock edge. Two combinational read ports, with same-cycle write bypass, serve instruction decode. A committed-write counter supports debug and performance checks.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- LINK_REG, 31, destination index forced by Jal
- LINK_OFS, 4, byte offset added to PC_Addr_Wr to form the link value

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- ALU_ans_Wr  in  DATA_W  ALU result from MEM/WR
- Mem_Data_Wr  in  DATA_W  load data from MEM/WR
- PC_Addr_Wr  in  DATA_W  address of the instruction in write-back
- Reg_Target_Wr  in  ADDR_W  decoded destination index
- MemToReg_Wr  in  1  select load data
- RegWr_Wr  in  1  write enable
- Rtype_L_Wr  in  1  R-type link (jalr): link value to Reg_Target_Wr
- Jal_Wr  in  1  jal: link value to LINK_REG
- Rs_Addr  in  ADDR_W  read port A index
- Rt_Addr  in  ADDR_W  read port B index
- Rs_Data  out  DATA_W  read port A data
- Rt_Data  out  DATA_W  read port B data
- Wb_En  out  1  effective write this cycle (for forwarding unit)
- Wb_Addr  out  ADDR_W  effective destination
- Wb_Data  out  DATA_W  effective write data
- Wr_Count  out  32  committed non-zero-register writes since reset

## Operation
- Link value = PC_Addr_Wr + LINK_OFS, modulo 2^DATA_W.
- Write-data priority: Jal_Wr or Rtype_L_Wr → link value; else MemToReg_Wr → Mem_Data_Wr; else ALU_ans_Wr.
- Destination: Jal_Wr → LINK_REG; otherwise Reg_Target_Wr.
- Wb_En = (RegWr_Wr | Jal_Wr) & (destination ≠ 0). Jal writes even if RegWr_Wr is low.
- Register 0 is hard-wired: reads return 0, writes discarded, never counted.
- Read ports: Rs_Data = 0 if Rs_Addr = 0; else Wb_Data if Wb_En and Rs_Addr = Wb_Addr (write-through bypass); else stored value. Rt_Data identical.
- Wr_Count increments by 1 on each rising edge with Wb_En high; wraps 0xFFFFFFFF → 0.
- Jal_Wr and Rtype_L_Wr both high: Jal destination wins, link value written.

## Timing
- Write commits at the rising edge of clk in the cycle Wb_En is high; visible in storage from the next cycle, and visible combinationally on read ports in the same cycle via bypass.
- Read ports, Wb_En/Wb_Addr/Wb_Data: purely combinational, zero latency.
- Reset: on rst assertion, all 32 registers and Wr_Count clear to 0 immediately, independent of clk. While rst is high no write commits and the counter holds 0; Rs_Data/Rt_Data read 0 except for bypass of the live Wb_Data (bypass is combinational and not masked by reset).
- Reset deasserted mid-instruction: the first rising edge after deassertion with Wb_En high commits normally.
- Both read ports may address the same register and/or the write destination simultaneously; both get the bypassed value.

## Structure
- Shared pipeline package holds DATA_W, ADDR_W, LINK_REG, LINK_OFS defaults and the register-zero constant, reused by decode and forwarding units.
- One sub-module: wb_data_sel (combinational link/mem/ALU mux and destination/enable generation), instanced once; storage, bypass and counter live in wb_regfile.

## Test plan
- Reset: write several registers, assert rst asynchronously between edges → all reads 0 immediately, Wr_Count = 0.
- ALU write: RegWr=1, Reg_Target=8, ALU_ans=0x12345678 → same-cycle Rs_Data(8)=0x12345678 via bypass; next cycle stored; Wr_Count +1.
- Load vs ALU: MemToReg=1, Mem_Data=0xDEADBEEF, ALU_ans=0x1 into reg 9 → reg 9 = 0xDEADBEEF.
- Jal: Jal=1, RegWr=0, PC_Addr=0x00400010, Reg_Target=5 → reg 31 = 0x00400014, reg 5 unchanged.
- Rtype_L: Rtype_L=1, RegWr=1, Reg_Target=4, PC_Addr=0xFFFFFFFC → reg 4 = 0x00000000 (wrap).
- Register zero: RegWr=1, Reg_Target=0, ALU_ans=0xFFFFFFFF → Rs_Data(0)=0, Wb_En=0, Wr_Count unchanged.
